// File: rtl/seg_scan_decoder_pkg.sv
// Shared seven-segment constants and anode helpers for the stopwatch display bus.
// Patterns are active low, {g,f,e,d,c,b,a}; an[3] is the leftmost (most significant) digit.
package seg_scan_decoder_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned AN_W      = 4;
  localparam int unsigned BCD_W     = 4;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [BCD_W-1:0] DIGIT_ERR = 4'hF;

  typedef enum logic [1:0] {
    CLS_BLANK,
    CLS_ACTIVE,
    CLS_OVERLAP
  } an_class_e;

  function automatic an_class_e classify_an(input logic [AN_W-1:0] an);
    case ($countones(~an))
      0:       return CLS_BLANK;
      1:       return CLS_ACTIVE;
      default: return CLS_OVERLAP;
    endcase
  endfunction

  // Index of the low anode bit; only meaningful when classify_an() is CLS_ACTIVE.
  function automatic logic [1:0] active_idx(input logic [AN_W-1:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < int'(AN_W); i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// Combinational seven-segment to BCD decode; unknown patterns map to DIGIT_ERR.
module seg7_to_bcd
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd_c,
  output logic       illegal_c
);

  always_comb begin
    bcd_c     = DIGIT_ERR;
    illegal_c = 1'b0;
    case (seg)
      SEG_0:   bcd_c = 4'd0;
      SEG_1:   bcd_c = 4'd1;
      SEG_2:   bcd_c = 4'd2;
      SEG_3:   bcd_c = 4'd3;
      SEG_4:   bcd_c = 4'd4;
      SEG_5:   bcd_c = 4'd5;
      SEG_6:   bcd_c = 4'd6;
      SEG_7:   bcd_c = 4'd7;
      SEG_8:   bcd_c = 4'd8;
      SEG_9:   bcd_c = 4'd9;
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed seven-segment bus and rebuilds the four displayed digits as BCD,
// flagging illegal patterns, overlapping anodes and a stalled scan. SETTLE_CYCLES must be >= 2.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 4000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        overlap_err,
  output logic        stale
);

  localparam int unsigned BUS_W   = AN_W + SEG_W;
  localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned STALE_W = $clog2(STALE_CYCLES + 1);

  logic [BUS_W-1:0] bus_s;
  logic [AN_W-1:0]  an_s;
  logic [SEG_W-1:0] seg_s;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign bus_s = {an, seg};
    end else begin : g_sync
      logic [BUS_W-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '1;
        end else begin
          sync_q[0] <= {an, seg};
          for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign bus_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign an_s  = bus_s[BUS_W-1:SEG_W];
  assign seg_s = bus_s[SEG_W-1:0];

  logic [BUS_W-1:0]   prev_q;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
  logic [15:0]        slot_q, slot_d;
  logic [3:0]         slot_err_q, slot_err_d;
  logic [3:0]         mask_q, mask_d;
  logic               seen_q, seen_d;
  logic [15:0]        digits_q, digits_d;
  logic [3:0]         digit_err_q, digit_err_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_changed_q, frame_changed_d;
  logic               overlap_q, overlap_d;
  logic               stale_q, stale_d;

  an_class_e  an_cls_c;
  logic [1:0] idx_c;
  logic       same_c;
  logic       capture_c;
  logic       done_c;
  logic [3:0] bcd_c;
  logic       illegal_c;

  assign an_cls_c  = classify_an(an_s);
  assign idx_c     = active_idx(an_s);
  assign same_c    = (bus_s == prev_q);
  assign capture_c = (an_cls_c == CLS_ACTIVE) && same_c && (settle_q == CNT_W'(SETTLE_CYCLES - 2));
  assign done_c    = (mask_q == 4'hF);

  seg7_to_bcd u_seg7 (
    .seg       (seg_s),
    .bcd_c     (bcd_c),
    .illegal_c (illegal_c)
  );

  always_comb begin
    settle_d        = '0;
    stale_cnt_d     = stale_cnt_q;
    slot_d          = slot_q;
    slot_err_d      = slot_err_q;
    mask_d          = mask_q;
    seen_d          = seen_q;
    digits_d        = digits_q;
    digit_err_d     = digit_err_q;
    frame_valid_d   = 1'b0;
    frame_changed_d = 1'b0;
    overlap_d       = overlap_q;

    if (an_cls_c == CLS_ACTIVE && same_c) begin
      settle_d = (settle_q == CNT_W'(SETTLE_CYCLES)) ? settle_q : settle_q + CNT_W'(1);
    end

    if (done_c) begin
      digits_d        = slot_q;
      digit_err_d     = slot_err_q;
      frame_valid_d   = 1'b1;
      frame_changed_d = seen_q && (slot_q != digits_q);
      seen_d          = 1'b1;
      mask_d          = 4'h0;
      overlap_d       = 1'b0;
      stale_cnt_d     = '0;
    end else if (stale_cnt_q != STALE_W'(STALE_CYCLES)) begin
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
    end

    // A capture landing on the completion cycle starts the next frame's mask.
    if (capture_c) begin
      slot_d[{idx_c, 2'b00} +: 4] = bcd_c;
      slot_err_d[idx_c]           = illegal_c;
      mask_d[idx_c]               = 1'b1;
    end

    if (an_cls_c == CLS_OVERLAP) overlap_d = 1'b1;

    stale_d = (stale_cnt_d == STALE_W'(STALE_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q          <= '1;
      settle_q        <= '0;
      stale_cnt_q     <= '0;
      slot_q          <= '0;
      slot_err_q      <= '0;
      mask_q          <= '0;
      seen_q          <= 1'b0;
      digits_q        <= '0;
      digit_err_q     <= '0;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      overlap_q       <= 1'b0;
      stale_q         <= 1'b0;
    end else begin
      prev_q          <= bus_s;
      settle_q        <= settle_d;
      stale_cnt_q     <= stale_cnt_d;
      slot_q          <= slot_d;
      slot_err_q      <= slot_err_d;
      mask_q          <= mask_d;
      seen_q          <= seen_d;
      digits_q        <= digits_d;
      digit_err_q     <= digit_err_d;
      frame_valid_q   <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
      overlap_q       <= overlap_d;
      stale_q         <= stale_d;
    end
  end

  assign digits        = digits_q;
  assign digit_err     = digit_err_q;
  assign frame_valid   = frame_valid_q;
  assign frame_changed = frame_changed_q;
  assign overlap_err   = overlap_q;
  assign stale         = stale_q;

endmodule
